// File: rtl/rx_byte_buffer_writer.sv
// Byte-stream frame capture into port A of a widening dual-port buffer.
// Qualifies frames by length and error flag, holds one good frame until acked, counts drops.
module rx_byte_buffer_writer #(
  parameter int ADDR_W    = 11,
  parameter int MAX_BYTES = 1536,
  parameter int MIN_BYTES = 60
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              rx_sof,
  input  logic              rx_eof,
  input  logic              rx_err,
  output logic              ena,
  output logic [1:0]        wea,
  output logic [ADDR_W-1:0] addra,
  output logic [15:0]       dina,
  output logic              frame_done,
  output logic [ADDR_W+1:0] frame_len,
  input  logic              frame_ack,
  output logic [15:0]       drop_cnt,
  output logic              busy
);

  localparam int CW = ADDR_W + 2;
  localparam logic [CW-1:0] MAX_C = CW'(MAX_BYTES);
  localparam logic [CW-1:0] MIN_C = CW'(MIN_BYTES);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  typedef enum logic [2:0] {
    IDLE, RECV, DROP, FIN, DONE, DROP_HOLD
  } state_t;

  state_t             r_state, w_state_nx;
  logic [CW-1:0]      r_cnt, w_cnt_nx;
  logic [CW-1:0]      r_len_pend, w_len_nx;
  logic               r_ack_pend, w_ack_nx;
  logic [CW-1:0]      r_frame_len;
  logic [15:0]        r_drop_cnt;
  logic               r_ena;
  logic [1:0]         r_wea;
  logic [ADDR_W-1:0]  r_addra;
  logic [15:0]        r_dina;
  logic               w_wr;
  logic [ADDR_W:0]    w_waddr;
  logic [1:0]         w_drop_inc;
  logic [CW-1:0]      w_len;

  function automatic logic f_len_ok(input logic [CW-1:0] len, input logic err);
    return (len >= MIN_C) && (len <= MAX_C) && !err;
  endfunction

  function automatic logic [15:0] f_sat_add(input logic [15:0] cur, input logic [1:0] inc);
    logic [16:0] sum;
    sum = {1'b0, cur} + {15'd0, inc};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  assign w_len = r_cnt + ONE_C;

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_len_nx   = r_len_pend;
    w_ack_nx   = r_ack_pend;
    w_wr       = 1'b0;
    w_waddr    = '0;
    w_drop_inc = 2'd0;
    case (r_state)
      IDLE: begin
        if (rx_valid && rx_sof) begin
          w_wr = 1'b1;
          if (rx_eof) begin
            if (f_len_ok(ONE_C, rx_err)) begin
              w_len_nx   = ONE_C;
              w_state_nx = FIN;
            end else begin
              w_drop_inc = 2'd1;
            end
          end else begin
            w_cnt_nx   = ONE_C;
            w_state_nx = RECV;
          end
        end
      end
      RECV: begin
        if (rx_valid) begin
          if (rx_sof) begin
            // Missing eof: count the broken frame, restart this byte at address 0.
            w_wr       = 1'b1;
            w_drop_inc = 2'd1;
            if (rx_eof) begin
              if (f_len_ok(ONE_C, rx_err)) begin
                w_len_nx   = ONE_C;
                w_state_nx = FIN;
              end else begin
                w_drop_inc = 2'd2;
                w_state_nx = IDLE;
              end
            end else begin
              w_cnt_nx = ONE_C;
            end
          end else if (rx_eof) begin
            w_wr    = (r_cnt < MAX_C);
            w_waddr = r_cnt[ADDR_W:0];
            if (f_len_ok(w_len, rx_err)) begin
              w_len_nx   = w_len;
              w_state_nx = FIN;
            end else begin
              w_drop_inc = 2'd1;
              w_state_nx = IDLE;
            end
          end else if (r_cnt == MAX_C) begin
            w_state_nx = DROP;
          end else begin
            w_wr     = 1'b1;
            w_waddr  = r_cnt[ADDR_W:0];
            w_cnt_nx = w_len;
          end
        end
      end
      DROP: begin
        if (rx_valid && rx_eof) begin
          w_drop_inc = 2'd1;
          w_state_nx = IDLE;
        end
      end
      FIN: w_state_nx = DONE;
      DONE: begin
        if (frame_ack || r_ack_pend) begin
          w_ack_nx   = 1'b0;
          w_state_nx = IDLE;
        end else if (rx_valid && rx_sof) begin
          if (rx_eof) w_drop_inc = 2'd1;
          else        w_state_nx = DROP_HOLD;
        end
      end
      DROP_HOLD: begin
        if (frame_ack) w_ack_nx = 1'b1;
        if (rx_valid && rx_eof) begin
          w_drop_inc = 2'd1;
          w_state_nx = DONE;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_len_pend  <= '0;
      r_ack_pend  <= 1'b0;
      r_frame_len <= '0;
      r_drop_cnt  <= '0;
      r_ena       <= 1'b0;
      r_wea       <= 2'b00;
      r_addra     <= '0;
      r_dina      <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_cnt      <= w_cnt_nx;
      r_len_pend <= w_len_nx;
      r_ack_pend <= w_ack_nx;
      r_drop_cnt <= f_sat_add(r_drop_cnt, w_drop_inc);
      if (r_state == FIN) r_frame_len <= r_len_pend;
      r_ena <= w_wr;
      r_wea <= w_wr ? (w_waddr[0] ? 2'b10 : 2'b01) : 2'b00;
      if (w_wr) begin
        r_addra <= w_waddr[ADDR_W:1];
        r_dina  <= {rx_data, rx_data};
      end
    end
  end

  assign ena        = r_ena;
  assign wea        = r_wea;
  assign addra      = r_addra;
  assign dina       = r_dina;
  assign frame_done = (r_state == DONE) || (r_state == DROP_HOLD);
  assign frame_len  = r_frame_len;
  assign drop_cnt   = r_drop_cnt;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_rx_byte_buffer_writer.sv
// Scoreboard bench for rx_byte_buffer_writer: expected port-A strobes queued at stimulus time,
// popped and compared as the write port fires.
module tb_rx_byte_buffer_writer;

  localparam int ADDR_W = 11;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'd0;
  logic              rx_sof = 1'b0;
  logic              rx_eof = 1'b0;
  logic              rx_err = 1'b0;
  logic              ena;
  logic [1:0]        wea;
  logic [ADDR_W-1:0] addra;
  logic [15:0]       dina;
  logic              frame_done;
  logic [ADDR_W+1:0] frame_len;
  logic              frame_ack = 1'b0;
  logic [15:0]       drop_cnt;
  logic              busy;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [1:0]        w;
    logic [15:0]       d;
  } wr_t;

  wr_t q[$];
  int  checks = 0;
  int  errors = 0;
  int  exp_drop = 0;

  rx_byte_buffer_writer #(.ADDR_W(ADDR_W), .MAX_BYTES(1536), .MIN_BYTES(60)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_sof(rx_sof),
    .rx_eof(rx_eof), .rx_err(rx_err), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .frame_done(frame_done), .frame_len(frame_len), .frame_ack(frame_ack),
    .drop_cnt(drop_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  // Write-port monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (ena) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL strobe_unexpected: addra=%0d wea=%b dina=%h, none required", addra, wea, dina);
      end else begin
        wr_t e;
        e = q.pop_front();
        if (addra !== e.a || wea !== e.w || dina !== e.d) begin
          errors++;
          $display("FAIL strobe: got addra=%0d wea=%b dina=%h, required addra=%0d wea=%b dina=%h",
                   addra, wea, dina, e.a, e.w, e.d);
        end
      end
    end else if (wea !== 2'b00) begin
      checks++;
      errors++;
      $display("FAIL wea_idle: got %b, required 00", wea);
    end
  end

  task automatic send_frame(input int len, input logic err, input logic push, input logic [7:0] seed);
    for (int i = 0; i < len; i++) begin
      @(posedge clk); #1;
      rx_valid = 1'b1;
      rx_data  = seed + 8'(i);
      rx_sof   = (i == 0);
      rx_eof   = (i == len - 1);
      rx_err   = err && (i == len - 1);
      if (push && i < 1536) begin
        wr_t e;
        e.a = ADDR_W'(i >> 1);
        e.w = i[0] ? 2'b10 : 2'b01;
        e.d = {rx_data, rx_data};
        q.push_back(e);
      end
    end
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0; rx_err = 1'b0;
  endtask

  task automatic do_ack();
    @(posedge clk); #1 frame_ack = 1'b1;
    @(posedge clk); #1 frame_ack = 1'b0;
    checks++;
    if (frame_done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ack_release: frame_done=%b busy=%b, required 0 0", frame_done, busy);
    end
  endtask

  task automatic check_good(input string name, input int len);
    checks++;
    if (frame_done !== 1'b0) begin
      errors++;
      $display("FAIL %s_done_early: frame_done=%b, required 0", name, frame_done);
    end
    @(posedge clk); #1;
    checks++;
    if (frame_done !== 1'b1 || frame_len !== 13'(len)) begin
      errors++;
      $display("FAIL %s_done: frame_done=%b frame_len=%0d, required 1 %0d", name, frame_done, frame_len, len);
    end
    checks++;
    if (drop_cnt !== 16'(exp_drop) || q.size() != 0) begin
      errors++;
      $display("FAIL %s_drop: drop_cnt=%0d pending=%0d, required %0d 0", name, drop_cnt, q.size(), exp_drop);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if (ena !== 1'b0 || wea !== 2'b00 || addra !== '0 || dina !== 16'h0 || frame_done !== 1'b0 ||
        frame_len !== '0 || drop_cnt !== 16'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset: ena=%b wea=%b addra=%0d dina=%h done=%b len=%0d drop=%0d busy=%b, required all 0",
               ena, wea, addra, dina, frame_done, frame_len, drop_cnt, busy);
    end
  endtask

  task automatic test_good64();
    send_frame(64, 1'b0, 1'b1, 8'h10);
    check_good("good64", 64);
    do_ack();
  endtask

  task automatic test_len61();
    send_frame(61, 1'b0, 1'b1, 8'hA0);
    check_good("len61", 61);
    do_ack();
  endtask

  task automatic test_drops();
    send_frame(1, 1'b0, 1'b1, 8'h55);
    send_frame(10, 1'b0, 1'b1, 8'h20);
    send_frame(64, 1'b1, 1'b1, 8'h30);
    exp_drop += 3;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (frame_done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL drops_state: frame_done=%b busy=%b, required 0 0", frame_done, busy);
      end
    end
    checks++;
    if (drop_cnt !== 16'(exp_drop) || q.size() != 0) begin
      errors++;
      $display("FAIL drops_count: drop_cnt=%0d pending=%0d, required %0d 0", drop_cnt, q.size(), exp_drop);
    end
  endtask

  task automatic test_oversize();
    send_frame(1600, 1'b0, 1'b1, 8'h00);
    exp_drop += 1;
    checks++;
    if (busy !== 1'b0 || frame_done !== 1'b0 || drop_cnt !== 16'(exp_drop)) begin
      errors++;
      $display("FAIL oversize: busy=%b done=%b drop_cnt=%0d, required 0 0 %0d", busy, frame_done, drop_cnt, exp_drop);
    end
    @(posedge clk); #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL oversize_strobes: pending=%0d, required 0", q.size());
    end
  endtask

  task automatic test_hold();
    send_frame(64, 1'b0, 1'b1, 8'h40);
    check_good("hold_first", 64);
    send_frame(100, 1'b0, 1'b0, 8'h80);
    exp_drop += 1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (frame_done !== 1'b1 || frame_len !== 13'd64 || drop_cnt !== 16'(exp_drop)) begin
      errors++;
      $display("FAIL hold: done=%b frame_len=%0d drop_cnt=%0d, required 1 64 %0d", frame_done, frame_len, drop_cnt, exp_drop);
    end
    do_ack();
    send_frame(70, 1'b0, 1'b1, 8'hC0);
    check_good("hold_next", 70);
    do_ack();
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      rx_valid = 1'b1;
      rx_data  = 8'h60 + 8'(i);
      rx_sof   = (i == 0);
      rx_eof   = 1'b0;
      begin
        wr_t e;
        e.a = ADDR_W'(i >> 1);
        e.w = i[0] ? 2'b10 : 2'b01;
        e.d = {rx_data, rx_data};
        q.push_back(e);
      end
    end
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_sof = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_drop = 0;
    checks++;
    if (ena !== 1'b0 || wea !== 2'b00 || addra !== '0 || dina !== 16'h0 || frame_done !== 1'b0 ||
        frame_len !== '0 || drop_cnt !== 16'h0 || busy !== 1'b0 || q.size() != 0) begin
      errors++;
      $display("FAIL mid_reset: ena=%b wea=%b addra=%0d dina=%h done=%b len=%0d drop=%0d busy=%b pending=%0d, required all 0",
               ena, wea, addra, dina, frame_done, frame_len, drop_cnt, busy, q.size());
    end
    send_frame(64, 1'b0, 1'b1, 8'hE0);
    check_good("after_reset", 64);
    do_ack();
  endtask

  initial begin
    test_reset();
    test_good64();
    test_len61();
    test_drops();
    test_oversize();
    test_hold();
    test_mid_reset();
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL final_pending: pending=%0d, required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
